// File: rtl/team_06_i2c_target.sv
// I2C target: 7-bit address match, write bytes out as strobes, optional read path.
// Read path is compiled in only when TEAM_06_I2C_TARGET_READ_EN is defined.
`timescale 1ns/1ps

// state      | meaning
// S_IDLE     | bus idle or after STOP, SDA released
// S_ADDR     | shifting address + R/W bit
// S_ADDR_ACK | address matched, ACK driven for one SCL low/high period
// S_RX       | shifting a write data byte
// S_RX_ACK   | ACK driven after a received byte
// S_TX       | presenting a read byte MSB-first
// S_TX_ACK   | sampling controller ACK/NACK
// S_IGNORE   | not addressed or NACKed, wait for START/STOP
module team_06_i2c_target #(
   parameter logic [6:0] ADDR = 7'h27
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_i,
   input  logic       sda_i,
   input  logic [7:0] tx_data,
   output logic       sda_o,
   output logic       oeb,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_first,
   output logic       tx_req,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACK, S_IGNORE
   } t_state;

`ifdef TEAM_06_I2C_TARGET_READ_EN
   localparam logic READ_EN = 1'b1;
`else
   localparam logic READ_EN = 1'b0;
`endif

   t_state     r_state;
   logic       r_scl_s1, r_scl_s2, r_scl_d;
   logic       r_sda_s1, r_sda_s2, r_sda_d;
   logic       r_scl_rise, r_scl_fall, r_start, r_stop, r_sda_bit;
   logic [3:0] r_cnt;
   logic [7:0] r_shift;
   logic [7:0] r_rx_data;
   logic       r_oeb, r_rx_valid, r_rx_first, r_tx_req, r_busy, r_rw;

   logic       w_sda_same;
   logic       w_scl_rise, w_scl_fall, w_start, w_stop;
   logic [7:0] w_byte;

   // SCL edges only count while SDA is stable, so a simultaneous change is no event
   assign w_sda_same = (r_sda_s2 == r_sda_d);
   assign w_scl_rise = r_scl_s2 & ~r_scl_d & w_sda_same;
   assign w_scl_fall = ~r_scl_s2 & r_scl_d & w_sda_same;
   assign w_start    = r_scl_s2 & r_scl_d & ~r_sda_s2 & r_sda_d;
   assign w_stop     = r_scl_s2 & r_scl_d & r_sda_s2 & ~r_sda_d;
   assign w_byte     = {r_shift[6:0], r_sda_bit};

   always_ff @(posedge clk) begin
      if (!rst) begin
         {r_scl_s1, r_scl_s2, r_scl_d} <= 3'b111;
         {r_sda_s1, r_sda_s2, r_sda_d} <= 3'b111;
         {r_scl_rise, r_scl_fall, r_start, r_stop} <= 4'b0000;
         r_sda_bit <= 1'b1;
      end else begin
         {r_scl_s1, r_scl_s2, r_scl_d} <= {scl_i, r_scl_s1, r_scl_s2};
         {r_sda_s1, r_sda_s2, r_sda_d} <= {sda_i, r_sda_s1, r_sda_s2};
         r_scl_rise <= w_scl_rise;
         r_scl_fall <= w_scl_fall;
         r_start    <= w_start;
         r_stop     <= w_stop;
         r_sda_bit  <= r_sda_s2;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= 4'd0;
         r_shift    <= 8'h00;
         r_rx_data  <= 8'h00;
         r_oeb      <= 1'b1;
         r_rx_valid <= 1'b0;
         r_rx_first <= 1'b0;
         r_tx_req   <= 1'b0;
         r_busy     <= 1'b0;
         r_rw       <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         r_tx_req   <= 1'b0;
         if (r_rx_valid) r_rx_first <= 1'b0;
`ifdef TEAM_06_I2C_TARGET_READ_EN
         if (r_tx_req) r_shift <= tx_data;
`endif
         if (r_start) begin
            r_state <= S_ADDR;
            r_cnt   <= 4'd0;
            r_oeb   <= 1'b1;
            r_busy  <= 1'b0;
         end else if (r_stop) begin
            r_state <= S_IDLE;
            r_oeb   <= 1'b1;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               S_ADDR: if (r_scl_rise) begin
                  r_shift <= w_byte;
                  r_cnt   <= r_cnt + 4'd1;
                  if (r_cnt == 4'd7) begin
                     if (w_byte[7:1] == ADDR && (READ_EN || !w_byte[0])) begin
                        r_state    <= S_ADDR_ACK;
                        r_busy     <= 1'b1;
                        r_rx_first <= 1'b1;
                        r_rw       <= w_byte[0];
                        r_tx_req   <= w_byte[0];
                     end else begin
                        r_state <= S_IGNORE;
                     end
                  end
               end
               // first falling edge starts the ACK, the second ends it
               S_ADDR_ACK: if (r_scl_fall) begin
                  if (r_oeb) begin
                     r_oeb <= 1'b0;
                  end else if (r_rw) begin
                     r_oeb   <= r_shift[7];
                     r_shift <= {r_shift[6:0], 1'b0};
                     r_cnt   <= 4'd1;
                     r_state <= S_TX;
                  end else begin
                     r_oeb   <= 1'b1;
                     r_cnt   <= 4'd0;
                     r_state <= S_RX;
                  end
               end
               S_RX: if (r_scl_rise) begin
                  r_shift <= w_byte;
                  r_cnt   <= r_cnt + 4'd1;
                  if (r_cnt == 4'd7) begin
                     r_rx_data  <= w_byte;
                     r_rx_valid <= 1'b1;
                     r_state    <= S_RX_ACK;
                  end
               end
               S_RX_ACK: if (r_scl_fall) begin
                  if (r_oeb) begin
                     r_oeb <= 1'b0;
                  end else begin
                     r_oeb   <= 1'b1;
                     r_cnt   <= 4'd0;
                     r_state <= S_RX;
                  end
               end
               S_TX: if (r_scl_fall) begin
                  if (r_cnt == 4'd8) begin
                     r_oeb   <= 1'b1;
                     r_state <= S_TX_ACK;
                  end else begin
                     r_oeb   <= r_shift[7];
                     r_shift <= {r_shift[6:0], 1'b0};
                     r_cnt   <= r_cnt + 4'd1;
                  end
               end
               S_TX_ACK: if (r_scl_rise) begin
                  if (!r_sda_bit) begin
                     r_tx_req <= 1'b1;
                     r_cnt    <= 4'd0;
                     r_state  <= S_TX;
                  end else begin
                     r_state <= S_IGNORE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign sda_o    = 1'b0;
   assign oeb      = r_oeb;
   assign rx_data  = r_rx_data;
   assign rx_valid = r_rx_valid;
   assign rx_first = r_rx_first;
   assign busy     = r_busy;
`ifdef TEAM_06_I2C_TARGET_READ_EN
   assign tx_req   = r_tx_req;
`else
   assign tx_req   = 1'b0;
   logic w_unused_tx;
   assign w_unused_tx = ^{tx_data, r_tx_req};
`endif

endmodule

// File: tb/tb_team_06_i2c_target.sv
// Directed bench for team_06_i2c_target: bit-level I2C controller model with a wired-AND SDA line.
`timescale 1ns/1ps

module tb_team_06_i2c_target;
   localparam int Q = 100;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       scl = 1'b1;
   logic       tb_sda = 1'b1;
   logic [7:0] tx_data = 8'hA5;
   logic       sda_o, oeb, rx_valid, rx_first, tx_req, busy;
   logic [7:0] rx_data;
   logic       line;

   assign line = tb_sda & (oeb | sda_o);

   always #12.5 clk = ~clk;

   team_06_i2c_target dut (
      .clk      (clk),
      .rst      (rst),
      .scl_i    (scl),
      .sda_i    (line),
      .tx_data  (tx_data),
      .sda_o    (sda_o),
      .oeb      (oeb),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_first (rx_first),
      .tx_req   (tx_req),
      .busy     (busy)
   );

   int         n_checks = 0;
   int         n_errors = 0;
   int         n_txreq  = 0;
   logic [8:0] rxq[$];

   always @(negedge clk) begin
      if (rx_valid === 1'b1) rxq.push_back({rx_first, rx_data});
      if (tx_req === 1'b1) n_txreq++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wq();
      repeat (Q) @(negedge clk);
   endtask

   task automatic bit_io(input logic b, output logic got);
      tb_sda = b; wq();
      scl = 1'b1; wq();
      got = line; wq();
      scl = 1'b0; wq();
   endtask

   task automatic i2c_start();
      if (scl == 1'b0) begin
         tb_sda = 1'b1; wq();
         scl = 1'b1; wq();
      end
      tb_sda = 1'b0; wq();
      scl = 1'b0; wq();
   endtask

   task automatic i2c_stop();
      tb_sda = 1'b0; wq();
      scl = 1'b1; wq();
      tb_sda = 1'b1; wq();
   endtask

   task automatic send_byte(input logic [7:0] d, output logic ack);
      logic g;
      for (int i = 7; i >= 0; i--) bit_io(d[i], g);
      bit_io(1'b1, ack);
   endtask

   task automatic read_byte(input logic m_ack, output logic [7:0] d);
      logic g;
      for (int i = 7; i >= 0; i--) bit_io(1'b1, d[i]);
      bit_io(m_ack, g);
   endtask

   task automatic get_rx(input int idx, output logic [8:0] v);
      v = 'x;
      if (rxq.size() > idx) v = rxq[idx];
   endtask

   initial begin
      logic       a, g;
      logic [7:0] d;
      logic [7:0] pat;
      logic [8:0] v;
      int         bad, nrx, ntx;

      // reset held with the bus toggling
      rst = 1'b0;
      repeat (2) @(negedge clk);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         scl    = 1'($urandom_range(0, 1));
         tb_sda = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (oeb !== 1'b1) bad++;
      end
      chk("rst_oeb_held", 32'(bad), 32'd0);
      chk("rst_rx_data", 32'(rx_data), 32'h00);
      chk("rst_rx_valid", 32'(rx_valid), 32'd0);
      chk("rst_rx_first", 32'(rx_first), 32'd0);
      chk("rst_tx_req", 32'(tx_req), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_sda_o", 32'(sda_o), 32'd0);
      scl = 1'b1; tb_sda = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (10) @(negedge clk);

      // write 0x22, 0xFF to 0x27
      nrx = rxq.size();
      i2c_start();
      send_byte(8'h4E, a); chk("wr_addr_ack", 32'(a), 32'd0);
      chk("wr_busy", 32'(busy), 32'd1);
      send_byte(8'h22, a); chk("wr_b0_ack", 32'(a), 32'd0);
      send_byte(8'hFF, a); chk("wr_b1_ack", 32'(a), 32'd0);
      i2c_stop();
      wq();
      chk("wr_rx_count", 32'(rxq.size() - nrx), 32'd2);
      get_rx(nrx, v);     chk("wr_rx0", 32'(v), 32'({1'b1, 8'h22}));
      get_rx(nrx + 1, v); chk("wr_rx1", 32'(v), 32'({1'b0, 8'hFF}));
      chk("wr_busy_after_stop", 32'(busy), 32'd0);

      // write to a foreign address
      nrx = rxq.size();
      i2c_start();
      send_byte(8'h4C, a); chk("nm_addr_nack", 32'(a), 32'd1);
      send_byte(8'h12, a); chk("nm_data_nack", 32'(a), 32'd1);
      chk("nm_busy", 32'(busy), 32'd0);
      i2c_stop();
      wq();
      chk("nm_rx_count", 32'(rxq.size() - nrx), 32'd0);

      // read two bytes, ACK then NACK
      ntx = n_txreq;
      tx_data = 8'hA5;
      i2c_start();
      send_byte(8'h4F, a);
`ifdef TEAM_06_I2C_TARGET_READ_EN
      chk("rd_addr_ack", 32'(a), 32'd0);
      tx_data = 8'h3C;
      read_byte(1'b0, d); chk("rd_byte0", 32'(d), 32'hA5);
      read_byte(1'b1, d); chk("rd_byte1", 32'(d), 32'h3C);
      chk("rd_release_after_nack", 32'(oeb), 32'd1);
      chk("rd_tx_req_count", 32'(n_txreq - ntx), 32'd2);
`else
      chk("rd_addr_nack", 32'(a), 32'd1);
      chk("rd_tx_req_count", 32'(n_txreq - ntx), 32'd0);
`endif
      i2c_stop();
      wq();

      // repeated START after 4 data bits
      nrx = rxq.size();
      i2c_start();
      send_byte(8'h4E, a); chk("rs_addr0_ack", 32'(a), 32'd0);
      bit_io(1'b1, g); bit_io(1'b0, g); bit_io(1'b1, g); bit_io(1'b1, g);
      i2c_start();
      send_byte(8'h4E, a); chk("rs_addr1_ack", 32'(a), 32'd0);
      send_byte(8'h80, a); chk("rs_data_ack", 32'(a), 32'd0);
      i2c_stop();
      wq();
      chk("rs_rx_count", 32'(rxq.size() - nrx), 32'd1);
      get_rx(nrx, v); chk("rs_rx0", 32'(v), 32'({1'b1, 8'h80}));

      // reset while the target drives an ACK
      i2c_start();
      send_byte(8'h4E, a); chk("ra_addr_ack", 32'(a), 32'd0);
      pat = 8'h96;
      for (int i = 7; i >= 0; i--) bit_io(pat[i], g);
      tb_sda = 1'b1;
      chk("ra_ack_driven", 32'(oeb), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("ra_oeb_next_clk", 32'(oeb), 32'd1);
      nrx = rxq.size();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      wq();
      scl = 1'b1; wq(); wq();
      scl = 1'b0; wq();
      chk("ra_rx_data_cleared", 32'(rx_data), 32'h00);
      send_byte(8'h55, a); chk("ra_ignored_nack", 32'(a), 32'd1);
      chk("ra_ignored_count", 32'(rxq.size() - nrx), 32'd0);
      i2c_start();
      send_byte(8'h4E, a); chk("ra_new_addr_ack", 32'(a), 32'd0);
      send_byte(8'h5A, a); chk("ra_new_data_ack", 32'(a), 32'd0);
      i2c_stop();
      wq();
      chk("ra_new_count", 32'(rxq.size() - nrx), 32'd1);
      get_rx(nrx, v); chk("ra_new_rx", 32'(v), 32'({1'b1, 8'h5A}));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
